// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - Control-unit / memory handshake and MAR/MDR strobe bundle for mem_access_ctrl
interface mem_access_ctrl_if;
   logic req;
   logic we;
   logic mem_ready;
   logic busy;
   logic done;
   logic err;
   logic MARin;
   logic MDRin;
   logic Read;
   logic mem_rd;
   logic mem_wr;

   // Sequencer side: takes requests and memory ready, drives strobes
   modport slave (
      input  req,
      input  we,
      input  mem_ready,
      output busy,
      output done,
      output err,
      output MARin,
      output MDRin,
      output Read,
      output mem_rd,
      output mem_wr
   );

   // Control unit / memory side
   modport master (
      output req,
      output we,
      output mem_ready,
      input  busy,
      input  done,
      input  err,
      input  MARin,
      input  MDRin,
      input  Read,
      input  mem_rd,
      input  mem_wr
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Moore sequencer for one MAR/MDR load or store per request; MEM_TIMEOUT_EN adds wait-state abort
module mem_access_ctrl #(
   parameter int MIN_WAIT       = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             clr,
   mem_access_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_WR_LOAD  = 3'd2;
   localparam logic [2:0] S_RD_WAIT  = 3'd3;
   localparam logic [2:0] S_RD_LATCH = 3'd4;
   localparam logic [2:0] S_WR_WAIT  = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;
`ifdef MEM_TIMEOUT_EN
   localparam logic [2:0] S_ERR      = 3'd7;
   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
`endif

   localparam logic [7:0] CNT_LAST = 8'(MIN_WAIT - 1);
   localparam logic [7:0] CNT_MAX  = 8'hFF;

   // Reject out-of-range configurations at elaboration
   if (MIN_WAIT < 1 || MIN_WAIT > 255 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
      $error("mem_access_ctrl: MIN_WAIT or TIMEOUT_CYCLES out of range");
   end

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       we_q, we_d;
   logic       wait_ok;
   logic       in_wait;

   // mem_ready only matters once the minimum strobe width has elapsed
   assign wait_ok = (cnt_q >= CNT_LAST) && bus.mem_ready;
   assign in_wait = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

   // Next-state, wait counter and access-type latch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            cnt_d   = 8'd0;
            state_d = we_q ? S_WR_LOAD : S_RD_WAIT;
         end
         S_WR_LOAD: begin
            cnt_d   = 8'd0;
            state_d = S_WR_WAIT;
         end
         S_RD_WAIT, S_WR_WAIT: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 8'd1;
            end
            // completion is tested first so it wins over a coincident timeout
            if (wait_ok) begin
               state_d = (state_q == S_RD_WAIT) ? S_RD_LATCH : S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q >= TO_LAST) begin
               state_d = S_ERR;
            end
`endif
         end
         S_RD_LATCH: state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any in-flight access without a done pulse
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
      end
   end

   // Outputs are a pure decode of the registered state
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.MARin  = (state_q == S_ADDR);
   assign bus.MDRin  = (state_q == S_WR_LOAD) || (state_q == S_RD_LATCH);
   assign bus.Read   = (state_q == S_RD_LATCH);
   assign bus.mem_rd = (state_q == S_RD_WAIT) || (state_q == S_RD_LATCH);
   assign bus.mem_wr = (state_q == S_WR_WAIT);
`ifdef MEM_TIMEOUT_EN
   assign bus.done   = (state_q == S_DONE) || (state_q == S_ERR);
   assign bus.err    = (state_q == S_ERR);
`else
   assign bus.done   = (state_q == S_DONE);
   assign bus.err    = 1'b0;
`endif

   // Strobes never overlap and MDR is only written in its two load states
   always_comb begin
      assert (clr !== 1'b1 || !(bus.mem_rd && bus.mem_wr));
      assert (clr !== 1'b1 || !(bus.MDRin && (in_wait && state_q != S_RD_LATCH)));
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - Scoreboard bench for mem_access_ctrl (MIN_WAIT=1 and MIN_WAIT=3 instances)
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic clr = 1'b0;

   mem_access_ctrl_if b0 ();
   mem_access_ctrl_if b3 ();

   mem_access_ctrl #(.MIN_WAIT(1), .TIMEOUT_CYCLES(8)) u0 (.clk(clk), .clr(clr), .bus(b0));
   mem_access_ctrl #(.MIN_WAIT(3), .TIMEOUT_CYCLES(8)) u3 (.clk(clk), .clr(clr), .bus(b3));

   always #5 clk = ~clk;

   // {busy, done, err, MARin, MDRin, Read, mem_rd, mem_wr}
   localparam logic [7:0] O_IDLE = 8'h00;
   localparam logic [7:0] O_ADDR = 8'h90;
   localparam logic [7:0] O_WRLD = 8'h88;
   localparam logic [7:0] O_RDW  = 8'h82;
   localparam logic [7:0] O_RDL  = 8'h8E;
   localparam logic [7:0] O_WRW  = 8'h81;
   localparam logic [7:0] O_DONE = 8'hC0;
   localparam logic [7:0] O_ERR  = 8'hE0;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   bit         type_q[$];
   logic [7:0] ev, obs;

   function automatic logic [7:0] sample(input bit sel3);
      if (sel3)
         return {b3.busy, b3.done, b3.err, b3.MARin, b3.MDRin, b3.Read, b3.mem_rd, b3.mem_wr};
      return {b0.busy, b0.done, b0.err, b0.MARin, b0.MDRin, b0.Read, b0.mem_rd, b0.mem_wr};
   endfunction

   task automatic push_access(input bit w, input int waits);
      exp_q.push_back(O_ADDR);
      if (w) begin
         exp_q.push_back(O_WRLD);
         repeat (waits) exp_q.push_back(O_WRW);
      end else begin
         repeat (waits) exp_q.push_back(O_RDW);
         exp_q.push_back(O_RDL);
      end
      exp_q.push_back(O_DONE);
      exp_q.push_back(O_IDLE);
   endtask

   // One-cycle request; we is flipped right after acceptance to show it is latched
   task automatic issue(input bit sel3, input bit w);
      @(negedge clk);
      if (sel3) begin b3.req = 1'b1; b3.we = w; end
      else      begin b0.req = 1'b1; b0.we = w; end
      @(posedge clk);
      #1;
      if (sel3) begin b3.req = 1'b0; b3.we = ~w; end
      else      begin b0.req = 1'b0; b0.we = ~w; end
   endtask

   task automatic test_reset;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         obs = sample(s[0]);
         n_assert++;
         if (obs !== O_IDLE) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: got %h expected %h", s, obs, O_IDLE);
         end
      end
      clr = 1'b1;
   endtask

   task automatic test_load;
      b0.mem_ready = 1'b1;
      push_access(1'b0, 1);
      issue(1'b0, 1'b0);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(negedge clk);
         ev = exp_q.pop_front(); obs = sample(1'b0); n_assert++;
         if (obs !== ev) begin
            n_fail++;
            $display("FAIL load cycle %0d: got %h expected %h", k, obs, ev);
         end
      end
   endtask

   task automatic test_store;
      b0.mem_ready = 1'b1;
      push_access(1'b1, 1);
      issue(1'b0, 1'b1);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(negedge clk);
         ev = exp_q.pop_front(); obs = sample(1'b0); n_assert++;
         if (obs !== ev) begin
            n_fail++;
            $display("FAIL store cycle %0d: got %h expected %h", k, obs, ev);
         end
      end
   endtask

   task automatic test_min_wait;
      b3.mem_ready = 1'b1;
      push_access(1'b0, 3);
      issue(1'b1, 1'b0);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(negedge clk);
         ev = exp_q.pop_front(); obs = sample(1'b1); n_assert++;
         if (obs !== ev) begin
            n_fail++;
            $display("FAIL min_wait3 cycle %0d: got %h expected %h", k, obs, ev);
         end
      end
   endtask

   task automatic test_timeout;
      b0.mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
      exp_q.push_back(O_ADDR);
      repeat (8) exp_q.push_back(O_RDW);
      exp_q.push_back(O_ERR);
      exp_q.push_back(O_IDLE);
      exp_q.push_back(O_IDLE);
`else
      push_access(1'b0, 10);
`endif
      issue(1'b0, 1'b0);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(negedge clk);
         ev = exp_q.pop_front(); obs = sample(1'b0); n_assert++;
         if (obs !== ev) begin
            n_fail++;
            $display("FAIL stall_ready cycle %0d: got %h expected %h", k, obs, ev);
         end
         if (k == 11) b0.mem_ready = 1'b1;
      end
   endtask

   task automatic test_reset_mid_read;
      b0.mem_ready = 1'b0;
      exp_q.push_back(O_ADDR);
      exp_q.push_back(O_RDW);
      exp_q.push_back(O_RDW);
      issue(1'b0, 1'b0);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(negedge clk);
         ev = exp_q.pop_front(); obs = sample(1'b0); n_assert++;
         if (obs !== ev) begin
            n_fail++;
            $display("FAIL pre_reset cycle %0d: got %h expected %h", k, obs, ev);
         end
      end
      #1 clr = 1'b0;
      #1;
      obs = sample(1'b0); n_assert++;
      if (obs !== O_IDLE) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %h expected %h", obs, O_IDLE);
      end
      @(negedge clk);
      clr = 1'b1;
      b0.mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         obs = sample(1'b0); n_assert++;
         if (obs !== O_IDLE) begin
            n_fail++;
            $display("FAIL post_reset_idle cycle %0d: got %h expected %h", k, obs, O_IDLE);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit seen_rd, seen_wr, tw, w;
      b0.mem_ready = 1'b1;
      @(negedge clk);
      b0.req = 1'b1;
      b0.we  = 1'b0;
      // we toggles every cycle; acceptances land on cycles 0, 5, 10, 15
      for (int i = 0; i < 4; i++) begin
         w = ((5 * i) % 2) == 1;
         push_access(w, 1);
         type_q.push_back(w);
      end
      seen_rd = 1'b0;
      seen_wr = 1'b0;
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(negedge clk);
         ev = exp_q.pop_front(); obs = sample(1'b0); n_assert++;
         if (obs !== ev) begin
            n_fail++;
            $display("FAIL b2b cycle %0d: got %h expected %h", k, obs, ev);
         end
         if (obs[1]) seen_rd = 1'b1;
         if (obs[0]) seen_wr = 1'b1;
         if (obs[6]) begin
            n_assert++;
            if (type_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_done cycle %0d: got extra done expected none", k);
            end else begin
               tw = type_q.pop_front();
               if ({seen_wr, seen_rd} !== {tw, ~tw}) begin
                  n_fail++;
                  $display("FAIL b2b_type cycle %0d: got wr=%0b rd=%0b expected we=%0b", k, seen_wr, seen_rd, tw);
               end
            end
            seen_rd = 1'b0;
            seen_wr = 1'b0;
         end
         b0.we = (k % 2) == 1;
         if (exp_q.size() == 0) b0.req = 1'b0;
      end
      n_assert++;
      if (type_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_pending: got %0d accesses without done expected 0", type_q.size());
      end
      @(negedge clk);
      obs = sample(1'b0); n_assert++;
      if (obs !== O_IDLE) begin
         n_fail++;
         $display("FAIL b2b_final_idle: got %h expected %h", obs, O_IDLE);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      b0.req = 1'b0; b0.we = 1'b0; b0.mem_ready = 1'b1;
      b3.req = 1'b0; b3.we = 1'b0; b3.mem_ready = 1'b1;
      test_reset();
      test_load();
      test_store();
      test_min_wait();
      test_timeout();
      test_reset_mid_read();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
